// File: rtl/stage5_lane_dispatch.sv
// Stage-5 lane dispatcher: accepts one message per cycle and hands it round-robin to one of
// three extraction lanes, holding each lane stable until the downstream consumer acknowledges it.
module stage5_lane_dispatch #(
    parameter int                MSG_W    = 32,
    parameter int                CTRL_W   = 4,
    parameter logic [CTRL_W-1:0] MUX_IDLE = {CTRL_W{1'b0}},
    parameter int                HOLD_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [MSG_W-1:0]  in_message_i,
    input  logic [CTRL_W-1:0] in_type_i,
    output logic              message_en_o,
    output logic [MSG_W-1:0]  message_1_o,
    output logic [MSG_W-1:0]  message_2_o,
    output logic [MSG_W-1:0]  message_3_o,
    output logic [CTRL_W-1:0] message_mux_control_m1_o,
    output logic [CTRL_W-1:0] message_mux_control_m2_o,
    output logic [CTRL_W-1:0] message_mux_control_m3_o,
    output logic [2:0]        lane_valid_o,
    input  logic [2:0]        lane_ack_i,
    output logic [15:0]       dispatch_cnt_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_VALID = 2'd2
    } lane_st_e;

    // The settle counter holds "cycles left after this one", so BUSY lasts exactly HOLD_CYC cycles.
    localparam logic [3:0] HOLD_LD = (HOLD_CYC == 0) ? 4'd0 : 4'(HOLD_CYC - 1);

    lane_st_e          state_q [3];
    logic [3:0]        hold_q  [3];
    logic [MSG_W-1:0]  msg_q   [3];
    logic [CTRL_W-1:0] ctrl_q  [3];
    logic [1:0]        rr_q;
    logic [1:0]        rr_d;
    logic              rdy_q;
    logic              en_q;
    logic [15:0]       cnt_q;
    logic [2:0]        empty_s;
    logic [2:0]        gnt_s;
    logic [2:0]        occ_d;
    logic              acc_s;

    // One-hot grant of the first empty lane at or after pointer p, wrapping 2 -> 0.
    function automatic logic [2:0] pick(input logic [2:0] e, input logic [1:0] p);
        logic [2:0] r;
        logic [2:0] g;
        logic [2:0] o;
        case (p)
            2'd1:    r = {e[0], e[2:1]};
            2'd2:    r = {e[1:0], e[2]};
            default: r = e;
        endcase
        if (r[0]) begin
            g = 3'b001;
        end else if (r[1]) begin
            g = 3'b010;
        end else if (r[2]) begin
            g = 3'b100;
        end else begin
            g = 3'b000;
        end
        case (p)
            2'd1:    o = {g[1:0], g[2]};
            2'd2:    o = {g[0], g[2:1]};
            default: o = g;
        endcase
        return o;
    endfunction

    // Grant selection and next-cycle lane occupancy, all from registered lane state.
    always_comb begin
        empty_s = 3'b000;
        occ_d   = 3'b000;
        for (int k = 0; k < 3; k++) begin
            empty_s[k] = (state_q[k] == ST_EMPTY);
        end
        acc_s = in_valid_i & rdy_q & (|empty_s);
        gnt_s = acc_s ? pick(empty_s, rr_q) : 3'b000;
        case (gnt_s)
            3'b001:  rr_d = 2'd1;
            3'b010:  rr_d = 2'd2;
            3'b100:  rr_d = 2'd0;
            default: rr_d = rr_q;
        endcase
        for (int k = 0; k < 3; k++) begin
            occ_d[k] = gnt_s[k] | (~empty_s[k] & ~((state_q[k] == ST_VALID) & lane_ack_i[k]));
        end
    end

    // Per-lane EMPTY/BUSY/VALID sequencing, payload capture, pointer and dispatch counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                state_q[k] <= ST_EMPTY;
                hold_q[k]  <= 4'd0;
                msg_q[k]   <= {MSG_W{1'b0}};
                ctrl_q[k]  <= MUX_IDLE;
            end
            rr_q  <= 2'd0;
            rdy_q <= 1'b0;
            en_q  <= 1'b0;
            cnt_q <= 16'd0;
        end else begin
            rdy_q <= 1'b1;
            en_q  <= |occ_d;
            rr_q  <= rr_d;
            if (|gnt_s) begin
                cnt_q <= cnt_q + 16'd1;
            end
            for (int k = 0; k < 3; k++) begin
                case (state_q[k])
                    ST_EMPTY: begin
                        if (gnt_s[k]) begin
                            msg_q[k]  <= in_message_i;
                            ctrl_q[k] <= in_type_i;
                            hold_q[k] <= HOLD_LD;
                            state_q[k] <= (HOLD_CYC == 0) ? ST_VALID : ST_BUSY;
                        end
                    end
                    ST_BUSY: begin
                        if (hold_q[k] == 4'd0) begin
                            state_q[k] <= ST_VALID;
                        end else begin
                            hold_q[k] <= hold_q[k] - 4'd1;
                        end
                    end
                    ST_VALID: begin
                        if (lane_ack_i[k]) begin
                            state_q[k] <= ST_EMPTY;
                            msg_q[k]   <= {MSG_W{1'b0}};
                            ctrl_q[k]  <= MUX_IDLE;
                        end
                    end
                    default: begin
                        state_q[k] <= ST_EMPTY;
                        msg_q[k]   <= {MSG_W{1'b0}};
                        ctrl_q[k]  <= MUX_IDLE;
                    end
                endcase
            end
        end
    end

    assign in_ready_o               = rdy_q & (|empty_s);
    assign message_en_o             = en_q;
    assign message_1_o              = msg_q[0];
    assign message_2_o              = msg_q[1];
    assign message_3_o              = msg_q[2];
    assign message_mux_control_m1_o = ctrl_q[0];
    assign message_mux_control_m2_o = ctrl_q[1];
    assign message_mux_control_m3_o = ctrl_q[2];
    assign lane_valid_o[0]          = (state_q[0] == ST_VALID);
    assign lane_valid_o[1]          = (state_q[1] == ST_VALID);
    assign lane_valid_o[2]          = (state_q[2] == ST_VALID);
    assign dispatch_cnt_o           = cnt_q;

endmodule

// File: tb/tb_stage5_lane_dispatch.sv
// Directed bench for stage5_lane_dispatch: a HOLD_CYC=2 instance with a payload scoreboard
// popped on each lane_valid rise, plus a HOLD_CYC=0 instance for zero-settle and counter wrap.
module tb_stage5_lane_dispatch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, message_en;
    logic [31:0] in_message, message_1, message_2, message_3;
    logic [3:0]  in_type, mux_1, mux_2, mux_3;
    logic [2:0]  lane_valid, lane_ack;
    logic [15:0] dcnt;

    logic        in_valid0, in_ready0, message_en0;
    logic [31:0] in_message0, message0_1, message0_2, message0_3;
    logic [3:0]  in_type0, mux0_1, mux0_2, mux0_3;
    logic [2:0]  lane_valid0, lane_ack0;
    logic [15:0] dcnt0;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;
    int acc      = 0;
    int guard    = 0;

    typedef struct {
        int          lane;
        logic [31:0] msg;
        logic [3:0]  ctrl;
    } exp_t;
    exp_t sbq[$];
    logic [2:0] lv_prev = 3'b000;

    always #5 clk = ~clk;

    stage5_lane_dispatch #(.MSG_W(32), .CTRL_W(4), .MUX_IDLE(4'h0), .HOLD_CYC(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_message_i(in_message), .in_type_i(in_type), .message_en_o(message_en),
        .message_1_o(message_1), .message_2_o(message_2), .message_3_o(message_3),
        .message_mux_control_m1_o(mux_1), .message_mux_control_m2_o(mux_2),
        .message_mux_control_m3_o(mux_3), .lane_valid_o(lane_valid), .lane_ack_i(lane_ack),
        .dispatch_cnt_o(dcnt)
    );

    stage5_lane_dispatch #(.MSG_W(32), .CTRL_W(4), .MUX_IDLE(4'h0), .HOLD_CYC(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid0), .in_ready_o(in_ready0),
        .in_message_i(in_message0), .in_type_i(in_type0), .message_en_o(message_en0),
        .message_1_o(message0_1), .message_2_o(message0_2), .message_3_o(message0_3),
        .message_mux_control_m1_o(mux0_1), .message_mux_control_m2_o(mux0_2),
        .message_mux_control_m3_o(mux0_3), .lane_valid_o(lane_valid0), .lane_ack_i(lane_ack0),
        .dispatch_cnt_o(dcnt0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int lane, input logic [31:0] msg, input logic [3:0] ctrl);
        in_valid   = 1'b1;
        in_message = msg;
        in_type    = ctrl;
        sbq.push_back('{lane: lane, msg: msg, ctrl: ctrl});
        exp_cnt++;
    endtask

    task automatic drain();
        int n = 0;
        while ((message_en !== 1'b0 || lane_valid !== 3'b000) && n < 20) begin
            lane_ack = lane_valid;
            step();
            n++;
        end
        lane_ack = 3'b000;
        chk("drain_en", {31'd0, message_en}, 32'd0);
    endtask

    // Scoreboard pop: each lane_valid rise must present the oldest payload queued for that lane.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (lane_valid[k] && !lv_prev[k]) begin
                int idx = -1;
                for (int j = 0; j < sbq.size(); j++) begin
                    if (idx < 0 && sbq[j].lane == k) idx = j;
                end
                if (idx < 0) begin
                    chk("sb_unexpected_lane", k, 32'hFFFF_FFFF);
                end else begin
                    chk("sb_msg", (k == 0) ? message_1 : (k == 1) ? message_2 : message_3, sbq[idx].msg);
                    chk("sb_ctrl", {28'd0, (k == 0) ? mux_1 : (k == 1) ? mux_2 : mux_3}, {28'd0, sbq[idx].ctrl});
                    sbq.delete(idx);
                end
            end
        end
        lv_prev = lane_valid;
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_message = 32'd0; in_type = 4'd0; lane_ack = 3'b000;
        in_valid0 = 1'b0; in_message0 = 32'd0; in_type0 = 4'd0; lane_ack0 = 3'b000;
        #2;
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_en", {31'd0, message_en}, 32'd0);
        chk("rst_lv", {29'd0, lane_valid}, 32'd0);
        chk("rst_cnt", {16'd0, dcnt}, 32'd0);
        chk("rst_mux1", {28'd0, mux_1}, 32'd0);
        step(); step();
        rst_n = 1'b1;
        chk("rel_ready_low", {31'd0, in_ready}, 32'd0);
        step();
        chk("rel_ready_high", {31'd0, in_ready}, 32'd1);

        // Single message, HOLD_CYC=2
        send(0, 32'hA5A5_A5A5, 4'h1);
        step(); in_valid = 1'b0;
        chk("t2_en", {31'd0, message_en}, 32'd1);
        chk("t2_msg1", message_1, 32'hA5A5_A5A5);
        chk("t2_mux1", {28'd0, mux_1}, 32'd1);
        chk("t2_cnt", {16'd0, dcnt}, exp_cnt);
        step();
        chk("t2_lv_t2", {29'd0, lane_valid}, 32'd0);
        step();
        chk("t2_lv_t3", {29'd0, lane_valid}, 32'd1);
        step(); lane_ack = 3'b001;
        chk("t2_en_t4", {31'd0, message_en}, 32'd1);
        step(); lane_ack = 3'b000;
        chk("t2_en_t5", {31'd0, message_en}, 32'd0);
        chk("t2_lv_t5", {29'd0, lane_valid}, 32'd0);
        chk("t2_msg1_clr", message_1, 32'd0);
        chk("t2_mux1_idle", {28'd0, mux_1}, 32'd0);

        // Fill all lanes (pointer now lane 2), then reset mid-operation
        send(1, 32'h1111_0001, 4'h2); step();
        send(2, 32'h1111_0002, 4'h3); step();
        send(0, 32'h1111_0003, 4'h4); step();
        in_valid = 1'b0;
        step(); step(); step();
        chk("fill_lv", {29'd0, lane_valid}, 32'd7);
        chk("fill_ready", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0; #1;
        exp_cnt = 0;
        chk("mid_rst_en", {31'd0, message_en}, 32'd0);
        chk("mid_rst_lv", {29'd0, lane_valid}, 32'd0);
        chk("mid_rst_cnt", {16'd0, dcnt}, 32'd0);
        chk("mid_rst_msg2", message_2, 32'd0);
        chk("mid_rst_mux3", {28'd0, mux_3}, 32'd0);
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
        step(); step();
        rst_n = 1'b1;
        chk("mid_rel_ready_low", {31'd0, in_ready}, 32'd0);
        step();
        chk("mid_rel_ready_high", {31'd0, in_ready}, 32'd1);

        // Round robin: four back-to-back messages, fourth stalls until lane 2 frees
        send(0, 32'h2222_0001, 4'h1); step();
        send(1, 32'h2222_0002, 4'h2); step();
        send(2, 32'h2222_0003, 4'h3); step();
        in_message = 32'h2222_0004; in_type = 4'h4;
        chk("rr_stall_ready", {31'd0, in_ready}, 32'd0);
        step();
        chk("rr_lv_c4", {29'd0, lane_valid}, 32'd3);
        chk("rr_cnt_c4", {16'd0, dcnt}, exp_cnt);
        lane_ack = 3'b010;
        step(); lane_ack = 3'b000;
        chk("rr_lv_c5", {29'd0, lane_valid}, 32'd5);
        chk("rr_msg2_clr", message_2, 32'd0);
        chk("rr_ready_c5", {31'd0, in_ready}, 32'd1);
        sbq.push_back('{lane: 1, msg: 32'h2222_0004, ctrl: 4'h4}); exp_cnt++;
        step(); in_valid = 1'b0;
        chk("rr_msg2_reload", message_2, 32'h2222_0004);
        chk("rr_cnt_c6", {16'd0, dcnt}, exp_cnt);
        lane_ack = 3'b101;
        step(); lane_ack = 3'b000;
        chk("rr_multi_ack_lv", {29'd0, lane_valid}, 32'd0);
        chk("rr_multi_ack_en", {31'd0, message_en}, 32'd1);
        send(2, 32'h2222_0005, 4'h5);
        step(); in_valid = 1'b0;
        chk("rr_ptr_lane3", message_3, 32'h2222_0005);
        chk("rr_ptr_lane1_idle", message_1, 32'd0);
        drain();

        // Simultaneous ack of lane 1 and accept: message goes to lane 2
        send(0, 32'h3333_0001, 4'h1); step();
        send(1, 32'h3333_0002, 4'h2); step();
        send(2, 32'h3333_0003, 4'h3); step();
        in_valid = 1'b0;
        step(); step();
        chk("sim_lv_full", {29'd0, lane_valid}, 32'd7);
        lane_ack = 3'b010;
        step(); lane_ack = 3'b000;
        chk("sim_lv_101", {29'd0, lane_valid}, 32'd5);
        lane_ack = 3'b001;
        send(1, 32'h3333_0004, 4'h0);
        step(); in_valid = 1'b0; lane_ack = 3'b000;
        chk("sim_msg2", message_2, 32'h3333_0004);
        chk("sim_msg1_empty", message_1, 32'd0);
        chk("sim_lv", {29'd0, lane_valid}, 32'd4);
        chk("sim_ready", {31'd0, in_ready}, 32'd1);
        chk("sim_cnt", {16'd0, dcnt}, exp_cnt);
        drain();

        // Acks on BUSY/EMPTY lanes are ignored
        send(2, 32'h4444_0000, 4'h0); step(); in_valid = 1'b0;
        drain();
        send(0, 32'h4444_0001, 4'h6);
        step(); in_valid = 1'b0; lane_ack = 3'b111;
        chk("ill_lv_e1", {29'd0, lane_valid}, 32'd0);
        step();
        chk("ill_lv_e2", {29'd0, lane_valid}, 32'd0);
        chk("ill_msg1_kept", message_1, 32'h4444_0001);
        chk("ill_msg2", message_2, 32'd0);
        chk("ill_ready", {31'd0, in_ready}, 32'd1);
        lane_ack = 3'b000;
        step();
        chk("ill_lv_e3", {29'd0, lane_valid}, 32'd1);
        chk("ill_cnt", {16'd0, dcnt}, exp_cnt);
        drain();
        chk("sb_empty", sbq.size(), 32'd0);

        // HOLD_CYC=0: lane_valid one cycle after accept
        in_valid0 = 1'b1; in_message0 = 32'h5555_0001; in_type0 = 4'h7;
        step(); in_valid0 = 1'b0;
        chk("h0_lv", {29'd0, lane_valid0}, 32'd1);
        chk("h0_msg1", message0_1, 32'h5555_0001);
        chk("h0_cnt", {16'd0, dcnt0}, 32'd1);
        lane_ack0 = 3'b001;
        step(); lane_ack0 = 3'b000;
        chk("h0_en_clr", {31'd0, message_en0}, 32'd0);

        // Counter wrap: stream until 65535 accepts, then one more
        acc = 1;
        while (acc < 65535 && guard < 70000) begin
            in_valid0 = 1'b1;
            in_message0 = acc;
            lane_ack0 = lane_valid0;
            if (in_ready0) acc++;
            step();
            guard++;
        end
        in_valid0 = 1'b0;
        lane_ack0 = 3'b000;
        chk("wrap_ffff", {16'd0, dcnt0}, 32'h0000_FFFF);
        in_valid0 = 1'b1;
        for (int g = 0; g < 10 && !in_ready0; g++) begin
            lane_ack0 = lane_valid0;
            step();
        end
        lane_ack0 = 3'b000;
        step(); in_valid0 = 1'b0;
        chk("wrap_zero", {16'd0, dcnt0}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
